// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 7-segment scan, debounces
// whole frames and offers stable BCD words on a valid/ready port.
module seg7_scan_capture #(
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  DIG,
  input  logic [6:0]  SEG,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [15:0] BCD,
  output logic [3:0]  BLANK,
  output logic        ERR
);
  typedef enum logic {COLLECT, PRESENT} state_t;

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);

  state_t      state_q, state_d;
  logic [3:0]  dig_r, dig_p1, dig_p2;
  logic [6:0]  seg_r;
  logic [15:0] nib_q, snap_nib, last_nib;
  logic [3:0]  blk_q, inv_q, mask_q;
  logic [3:0]  snap_blk, last_blk, cnt_q;
  logic        delivered;
  logic        onehot, cap, done, bad, same;
  logic        qualify, load, accept;
  logic [3:0]  dec_nib;
  logic        dec_blk, dec_inv;

  assign onehot = (dig_r != 4'd0) &&
                  ((dig_r & (dig_r - 4'd1)) == 4'd0);
  // second stable cycle of a fresh activation
  assign cap  = onehot && (dig_r == dig_p1) &&
                (dig_p1 != dig_p2);
  assign done = (mask_q == 4'hF);
  assign bad  = |inv_q;
  assign same = ({nib_q, blk_q} == {snap_nib, snap_blk});
  assign qualify = (cnt_q >= SF) &&
                   (({snap_nib, snap_blk} !=
                     {last_nib, last_blk}) || !delivered);

  always_comb begin
    dec_nib = 4'hF;
    dec_blk = 1'b0;
    dec_inv = 1'b0;
    unique case (seg_r)
      7'h7E:        dec_nib = 4'd0;
      7'h30:        dec_nib = 4'd1;
      7'h6D:        dec_nib = 4'd2;
      7'h79:        dec_nib = 4'd3;
      7'h33:        dec_nib = 4'd4;
      7'h5B:        dec_nib = 4'd5;
      7'h5F, 7'h1F: dec_nib = 4'd6;
      7'h70, 7'h72: dec_nib = 4'd7;
      7'h7F:        dec_nib = 4'd8;
      7'h7B, 7'h73: dec_nib = 4'd9;
      7'h00: begin
        dec_nib = 4'd0;
        dec_blk = 1'b1;
      end
      default:      dec_inv = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dig_r  <= '0;
      seg_r  <= '0;
      dig_p1 <= '0;
      dig_p2 <= '0;
    end else begin
      dig_r  <= DIG;
      seg_r  <= SEG;
      dig_p1 <= dig_r;
      dig_p2 <= dig_p1;
    end
  end

  // a capture on the completion edge opens the next frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nib_q  <= '0;
      blk_q  <= '0;
      inv_q  <= '0;
      mask_q <= '0;
    end else begin
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          if (dig_r[i]) begin
            nib_q[4*i +: 4] <= dec_nib;
            blk_q[i]        <= dec_blk;
            inv_q[i]        <= dec_inv;
          end
        end
      end
      if (done)
        mask_q <= cap ? dig_r : 4'd0;
      else if (cap)
        mask_q <= mask_q | dig_r;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_nib <= '0;
      snap_blk <= '0;
      cnt_q    <= '0;
      ERR      <= 1'b0;
    end else begin
      ERR <= done && bad;
      if (done) begin
        if (bad) begin
          cnt_q <= 4'd0;
        end else if (same) begin
          if (cnt_q != 4'hF)
            cnt_q <= cnt_q + 4'd1;
        end else begin
          snap_nib <= nib_q;
          snap_blk <= blk_q;
          cnt_q    <= 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      COLLECT:
        if (qualify) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      PRESENT:
        if (OUT_READY) begin
          accept  = 1'b1;
          state_d = COLLECT;
        end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      BCD       <= '0;
      BLANK     <= '0;
      last_nib  <= '0;
      last_blk  <= '0;
      delivered <= 1'b0;
    end else if (load) begin
      OUT_VALID <= 1'b1;
      BCD       <= snap_nib;
      BLANK     <= snap_blk;
    end else if (accept) begin
      OUT_VALID <= 1'b0;
      last_nib  <= BCD;
      last_blk  <= BLANK;
      delivered <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: vector table, directed corner sequences and a
// random frame stream checked against a frame-level reference model.
module tb_seg7_scan_capture;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  DIG = '0;
  logic [6:0]  SEG = '0;
  logic        OUT_READY = 1'b0;
  logic        OUT_VALID, ERR;
  logic [15:0] BCD;
  logic [3:0]  BLANK;

  int checks = 0;
  int fails  = 0;

  logic [19:0] got[$];
  int   err_seen  = 0;
  int   gap_viol  = 0;
  int   hold_viol = 0;
  logic prev_acc  = 1'b0;
  logic prev_wait = 1'b0;
  logic [19:0] prev_word = '0;

  typedef struct {
    logic [27:0] segs;
    logic [15:0] bcd;
    logic [3:0]  blank;
    bit          bad;
  } vec_t;
  vec_t vecs[7];

  seg7_scan_capture #(.STABLE_FRAMES(3)) dut (
    .CLK(CLK), .RST(RST), .DIG(DIG), .SEG(SEG),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
    .BCD(BCD), .BLANK(BLANK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST) begin
      prev_acc  = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_acc && OUT_VALID) gap_viol++;
      if (prev_wait && (!OUT_VALID || {BLANK, BCD} != prev_word))
        hold_viol++;
      if (OUT_VALID && OUT_READY) got.push_back({BLANK, BCD});
      if (ERR) err_seen++;
      prev_acc  = OUT_VALID && OUT_READY;
      prev_wait = OUT_VALID && !OUT_READY;
      prev_word = {BLANK, BCD};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input int d, input bit alt);
    case (d)
      0: return 7'h7E;
      1: return 7'h30;
      2: return 7'h6D;
      3: return 7'h79;
      4: return 7'h33;
      5: return 7'h5B;
      6: return alt ? 7'h1F : 7'h5F;
      7: return alt ? 7'h72 : 7'h70;
      8: return 7'h7F;
      9: return alt ? 7'h73 : 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic bit is_valid(input logic [6:0] p);
    if (p == 7'h00) return 1'b1;
    for (int d = 0; d < 10; d++)
      for (int a = 0; a < 2; a++)
        if (seg_of(d, a[0]) == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] rand_invalid();
    logic [6:0] p;
    do p = 7'($urandom_range(1, 127)); while (is_valid(p));
    return p;
  endfunction

  function automatic logic [27:0] word_segs(input logic [15:0] w);
    return {seg_of(int'(w[15:12]), 1'b0), seg_of(int'(w[11:8]), 1'b0),
            seg_of(int'(w[7:4]), 1'b0), seg_of(int'(w[3:0]), 1'b0)};
  endfunction

  function automatic logic [19:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 20'hxxxxx;
  endfunction

  task automatic scan_digit(input int i, input logic [6:0] s,
                            input int hold);
    DIG = 4'b0001 << i;
    SEG = s;
    repeat (hold) step;
  endtask

  task automatic scan_frame(input logic [27:0] segs, input int hold,
                            input bit glitch);
    for (int i = 3; i >= 0; i--) begin
      scan_digit(i, segs[i*7 +: 7], hold);
      if (glitch && i == 1) begin
        DIG = 4'b0011;
        step;
        DIG = 4'b0010;
        repeat (hold) step;
      end
    end
  endtask

  task automatic idle(input int n);
    DIG = '0;
    repeat (n) step;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    DIG = '0;
    SEG = '0;
    step;
    step;
    RST = 1'b0;
    got.delete();
    err_seen = 0;
  endtask

  task automatic wait_valid(input int max, input string nm);
    int k = 0;
    while (!OUT_VALID && k < max) begin
      step;
      k++;
    end
    chk(nm, 32'(OUT_VALID), 1);
  endtask

  // random-test model state
  int          pool[3][4];
  logic [19:0] exp_q[$];
  logic [19:0] m_snap, m_last, w;
  int          m_cnt, exp_err, cur, run, badpos, d;
  bit          m_deliv, fbad;
  logic [27:0] fsegs, ws;
  logic [15:0] fbcd;
  logic [3:0]  fblk;
  int          k, bad_n;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{{7'h7E, 7'h30, 7'h6D, 7'h79}, 16'h0123, 4'b0000, 1'b0};
    vecs[1] = '{{7'h33, 7'h5B, 7'h5F, 7'h1F}, 16'h4566, 4'b0000, 1'b0};
    vecs[2] = '{{7'h70, 7'h72, 7'h7F, 7'h7B}, 16'h7789, 4'b0000, 1'b0};
    vecs[3] = '{{7'h73, 7'h00, 7'h7E, 7'h30}, 16'h9001, 4'b0100, 1'b0};
    vecs[4] = '{{7'h6D, 7'h49, 7'h79, 7'h33}, 16'h0000, 4'b0000, 1'b1};
    vecs[5] = '{{7'h00, 7'h00, 7'h00, 7'h00}, 16'h0000, 4'b1111, 1'b0};
    vecs[6] = '{{7'h7F, 7'h7B, 7'h7F, 7'h7B}, 16'h8989, 4'b0000, 1'b0};

    step;
    step;
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_bcd", 32'(BCD), 0);
    chk("rst_blank", 32'(BLANK), 0);
    chk("rst_err", 32'(ERR), 0);
    RST = 1'b0;
    step;
    chk("post_rst_valid", 32'(OUT_VALID), 0);

    // decode table
    do_reset;
    OUT_READY = 1'b1;
    for (int v = 0; v < 7; v++) begin
      got.delete();
      err_seen = 0;
      repeat (3) scan_frame(vecs[v].segs, 6, 1'b0);
      idle(4);
      chk($sformatf("vec%0d_err", v), err_seen, vecs[v].bad ? 3 : 0);
      chk($sformatf("vec%0d_words", v), got.size(),
          vecs[v].bad ? 0 : 1);
      if (!vecs[v].bad)
        chk($sformatf("vec%0d_word", v), 32'(got_at(0)),
            32'({vecs[v].blank, vecs[v].bcd}));
    end

    // three frames of 1234 with end-to-end latency
    do_reset;
    OUT_READY = 1'b1;
    ws = word_segs(16'h1234);
    repeat (2) scan_frame(ws, 8, 1'b0);
    for (int i = 3; i >= 1; i--) scan_digit(i, ws[i*7 +: 7], 8);
    DIG = 4'b0001;
    SEG = ws[6:0];
    k = 0;
    while (!OUT_VALID && k < 20) begin
      step;
      k++;
    end
    chk("r21_latency", k, 5);
    chk("r21_bcd", 32'(BCD), 32'h1234);
    chk("r21_blank", 32'(BLANK), 0);
    repeat (8) step;
    idle(4);
    chk("r21_words", got.size(), 1);
    chk("r21_word", 32'(got_at(0)), 32'h01234);

    // short run is not reported
    do_reset;
    OUT_READY = 1'b1;
    repeat (2) scan_frame(word_segs(16'h1234), 8, 1'b0);
    repeat (3) scan_frame(word_segs(16'h1235), 8, 1'b0);
    idle(6);
    chk("r22_words", got.size(), 1);
    chk("r22_word", 32'(got_at(0)), 32'h01235);

    // back-pressure while the scan changes
    do_reset;
    OUT_READY = 1'b0;
    repeat (3) scan_frame(word_segs(16'h1234), 8, 1'b0);
    wait_valid(10, "r23_valid");
    chk("r23_bcd", 32'(BCD), 32'h1234);
    bad_n = 0;
    fork
      repeat (4) scan_frame(word_segs(16'h5678), 8, 1'b0);
      begin
        repeat (20) begin
          step;
          if (!OUT_VALID || BCD !== 16'h1234) bad_n++;
        end
        chk("r23_hold", bad_n, 0);
        OUT_READY = 1'b1;
      end
    join
    idle(6);
    chk("r23_words", got.size(), 2);
    chk("r23_word0", 32'(got_at(0)), 32'h01234);
    chk("r23_word1", 32'(got_at(1)), 32'h05678);

    // invalid segment pattern in slot 2
    do_reset;
    OUT_READY = 1'b1;
    repeat (2) scan_frame(word_segs(16'h1234), 8, 1'b0);
    scan_frame({7'h30, 7'h49, 7'h79, 7'h33}, 8, 1'b0);
    idle(4);
    chk("r24_err", err_seen, 1);
    chk("r24_words_a", got.size(), 0);
    repeat (2) scan_frame(word_segs(16'h1234), 8, 1'b0);
    idle(4);
    chk("r24_words_b", got.size(), 0);
    scan_frame(word_segs(16'h1234), 8, 1'b0);
    idle(6);
    chk("r24_words_c", got.size(), 1);
    chk("r24_word", 32'(got_at(0)), 32'h01234);

    // blank digit plus a two-hot select glitch
    do_reset;
    OUT_READY = 1'b1;
    repeat (3) scan_frame({7'h00, 7'h6D, 7'h79, 7'h33}, 8, 1'b1);
    idle(6);
    chk("r25_words", got.size(), 1);
    chk("r25_word", 32'(got_at(0)), 32'h80234);
    chk("r25_err", err_seen, 0);

    // reset during PRESENT, then a mid-frame reset
    do_reset;
    OUT_READY = 1'b0;
    repeat (3) scan_frame(word_segs(16'h1234), 8, 1'b0);
    wait_valid(10, "r26_valid");
    #2;
    RST = 1'b1;
    #1;
    chk("r26_valid0", 32'(OUT_VALID), 0);
    chk("r26_bcd0", 32'(BCD), 0);
    chk("r26_blank0", 32'(BLANK), 0);
    chk("r26_err0", 32'(ERR), 0);
    do_reset;
    OUT_READY = 1'b1;
    ws = word_segs(16'h1234);
    repeat (2) scan_frame(ws, 8, 1'b0);
    scan_digit(3, ws[27:21], 8);
    scan_digit(2, ws[20:14], 8);
    do_reset;
    repeat (2) scan_frame(ws, 8, 1'b0);
    idle(6);
    chk("r26_words_a", got.size(), 0);
    scan_frame(ws, 8, 1'b0);
    idle(6);
    chk("r26_words_b", got.size(), 1);
    chk("r26_word", 32'(got_at(0)), 32'h01234);

    // random frame stream
    do_reset;
    OUT_READY = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) pool[p][i] = $urandom_range(0, 10);
    m_snap = '0;
    m_last = '0;
    m_cnt = 0;
    m_deliv = 1'b0;
    exp_err = 0;
    run = 0;
    cur = 0;
    for (int f = 0; f < 40; f++) begin
      if (run == 0) begin
        cur = $urandom_range(0, 2);
        run = $urandom_range(1, 5);
      end
      run--;
      badpos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      fbad = 1'b0;
      fbcd = '0;
      fblk = '0;
      for (int i = 0; i < 4; i++) begin
        d = pool[cur][i];
        if (i == badpos) begin
          fsegs[i*7 +: 7] = rand_invalid();
          fbad = 1'b1;
        end else begin
          fsegs[i*7 +: 7] = seg_of(d, $urandom_range(0, 1) == 1);
          fbcd[i*4 +: 4] = (d == 10) ? 4'd0 : 4'(d);
          fblk[i] = (d == 10);
        end
      end
      for (int i = 3; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) begin
          DIG = '0;
          step;
        end
        scan_digit(i, fsegs[i*7 +: 7], $urandom_range(2, 6));
      end
      if (fbad) begin
        exp_err++;
        m_cnt = 0;
      end else begin
        w = {fblk, fbcd};
        if (w == m_snap) begin
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end else begin
          m_snap = w;
          m_cnt = 1;
        end
        if (m_cnt >= 3 && (m_snap != m_last || !m_deliv)) begin
          exp_q.push_back(m_snap);
          m_last = m_snap;
          m_deliv = 1'b1;
        end
      end
    end
    idle(8);
    chk("rnd_words", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_word%0d", i), 32'(got_at(i)), 32'(exp_q[i]));
    chk("rnd_err", err_seen, exp_err);

    chk("valid_gap", gap_viol, 0);
    chk("valid_hold", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 The block SHALL have parameter STABLE_FRAMES, default 3, range 1-15: the number of consecutive identical scan frames required before a word is reported.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-high reset.
- DIG  in  4  active-high one-hot digit select from the scanned display; bit 3 is the most significant digit.
- SEG  in  7  active-high segments {a,b,c,d,e,f,g}; SEG[6]=a.
- OUT_READY  in  1  downstream accepts a word.
- OUT_VALID  out  1  word available.
- BCD  out  16  decoded digits; digit3 is in [15:12].
- BLANK  out  4  per-digit blank flag (all segments off).
- ERR  out  1  one-cycle pulse: the completed frame contained an undecodable pattern.

Function
REQ-003 DIG and SEG SHALL be registered once on entry (DIG_r, SEG_r); all decoding SHALL use only the registered values.
REQ-004 A digit capture SHALL occur on the cycle where DIG_r is one-hot, DIG_r equals its previous-cycle value, and the previous-cycle value differed from the value two cycles earlier; this is exactly one capture per digit activation, on its second stable cycle.
REQ-005 A DIG_r value that is zero or has more than one bit set SHALL cause no capture and SHALL leave all state unchanged.
REQ-006 Decode of SEG_r (a..g, as a 7-bit string) SHALL be:
- 0 = 1111110
- 1 = 0110000
- 2 = 1101101
- 3 = 1111001
- 4 = 0110011
- 5 = 1011011
- 6 = 1011111 or 0011111
- 7 = 1110000 or 1110010
- 8 = 1111111
- 9 = 1111011 or 1110011
REQ-007 The all-off pattern 0000000 SHALL decode to nibble 0 with the blank bit set; any other pattern is invalid and SHALL decode to nibble 0xF with the invalid bit set.
REQ-008 A capture SHALL write the nibble, blank bit and invalid bit into the digit slot given by DIG_r, and SHALL set that slot's bit in a 4-bit capture mask.
- A re-capture of an already-masked digit SHALL overwrite that slot.
REQ-009 A frame SHALL complete on the cycle the mask becomes 1111.
- The mask SHALL clear on the same edge.
- A capture on that edge SHALL belong to the next frame.
REQ-010 On frame completion, if any slot's invalid bit is set:
- ERR SHALL pulse high for exactly the next cycle;
- the stability count SHALL clear to 0;
- the snapshot SHALL be left unchanged.
REQ-011 On completion of a valid frame, the frame's slots (16-bit nibbles plus 4 blank bits) SHALL be compared with the snapshot:
- equal: the count SHALL increment, saturating at 15;
- different: the snapshot SHALL load the frame and the count SHALL be set to 1.
REQ-012 The state machine SHALL have two states, COLLECT and PRESENT.
REQ-013 In COLLECT, if count >= STABLE_FRAMES after the update and the snapshot differs from the last delivered word, or no word has been delivered since reset:
- the state SHALL move to PRESENT;
- BCD and BLANK SHALL load from the snapshot;
- OUT_VALID SHALL assert on the next cycle.
- With STABLE_FRAMES=1, the first valid frame qualifies.
REQ-014 In PRESENT, OUT_VALID, BCD and BLANK SHALL hold constant until a cycle with OUT_VALID=1 and OUT_READY=1.
- On that cycle's edge the last-delivered register SHALL load BCD/BLANK, the delivered flag SHALL set, and the state SHALL return to COLLECT.
- OUT_VALID SHALL therefore be low for at least one cycle between words.
REQ-015 Frame capture, snapshot and count updates SHALL continue while in PRESENT.
- A word that qualifies during PRESENT SHALL be offered after the return to COLLECT, if it still qualifies then.
REQ-016 OUT_READY high while OUT_VALID is low SHALL have no effect.
REQ-017 If frame completion and a handshake occur on the same edge, both SHALL take effect.
- Qualification for the new frame SHALL be judged against the word delivered on that edge.
REQ-018 The latency from the capture that completes a qualifying frame to OUT_VALID high SHALL be 2 cycles (completion edge, then load edge).
- The latency from a pin change to its capture SHALL be 3 cycles.

Reset
REQ-019 RST high SHALL asynchronously force all of the following to zero: OUT_VALID, BCD, BLANK, ERR, the mask, the count, the snapshot, the last-delivered register and the delivered flag; the state SHALL go to COLLECT and the input registers to zero.
REQ-020 Reset asserted mid-frame or during PRESENT SHALL discard the partial frame and the pending word.
- After release, the first complete frame SHALL start a fresh count.

Verification
REQ-021 Scan "1234" for 3 frames, each digit held 8 cycles, with OUT_READY=1 -> exactly one OUT_VALID pulse, BCD=0x1234, BLANK=0000.
REQ-022 Scan 0x1234 for 2 frames, then 0x1235 for 3 frames -> no word for 0x1234; one word 0x1235.
REQ-023 Hold OUT_READY=0 for 20 cycles after OUT_VALID rises while scanning changes to "5678" -> BCD stays 0x1234 until the handshake; 0x5678 is offered after an OUT_VALID low cycle.
REQ-024 Digit 2 shows 1001001 in one frame -> one-cycle ERR pulse, count cleared; 3 further good frames are then required before OUT_VALID.
REQ-025 Digit 3 is all-off and DIG=0011 glitches for 1 cycle -> the glitch is ignored, BLANK=1000 and BCD[15:12]=0.
REQ-026 Assert RST during PRESENT -> all outputs 0 immediately; after release, 3 frames of "1234" re-deliver 0x1234.
